// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter
//   Registered binary/Gray pointer counter for CDC FIFO pointers. The Gray copy
//   is its own flop bank loaded from the next-state value, so it can be
//   synchronised into another clock domain without decode glitches.
// Parameters
//   WIDTH    counter / Gray width in bits (>=2)
//   SATURATE 0: wrap modulo 2**WIDTH, 1: saturate at MAXCNT
//   MAXCNT   terminal count when SATURATE=1 (<= 2**WIDTH-1)
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   inc        advance count by one
//   clr        synchronous clear of count and ovf (highest priority)
//   load       synchronous load of load_val (clamped to TC when saturating)
//   load_val   binary value to load
//   bin_out    registered binary count
//   gray_out   registered Gray count
//   gray_next  combinational Gray of the next count (lookahead compares)
//   at_max     registered, count equals terminal count
//   ovf        registered sticky overflow flag
module gray_ptr_counter #(
   parameter int unsigned WIDTH    = 5,
   parameter bit          SATURATE = 1'b0,
   parameter int unsigned MAXCNT   = (2**WIDTH) - 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] gray_next,
   output logic             at_max,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] TC         = SATURATE ? WIDTH'(MAXCNT) : {WIDTH{1'b1}};
   localparam logic             AT_MAX_RST = (TC == {WIDTH{1'b0}});

   logic [WIDTH-1:0] next_bin;
   logic             next_ovf;

   // Next count and overflow, priority clr > load > inc > hold
   always_comb begin
      next_bin = bin_out;
      next_ovf = ovf;
      if (clr) begin
         next_bin = '0;
         next_ovf = 1'b0;
      end else if (load) begin
         if (SATURATE && (load_val > TC)) begin
            next_bin = TC;
         end else begin
            next_bin = load_val;
         end
      end else if (inc) begin
         if (bin_out < TC) begin
            next_bin = bin_out + WIDTH'(1);
         end else begin
            // At terminal count: hold when saturating, otherwise wrap to zero
            next_bin = SATURATE ? TC : '0;
            next_ovf = 1'b1;
         end
      end
   end

   // Gray of the next value feeds both the lookahead output and the Gray flops
   assign gray_next = next_bin ^ (next_bin >> 1);

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bin_out  <= '0;
         gray_out <= '0;
         at_max   <= AT_MAX_RST;
         ovf      <= 1'b0;
      end else begin
         bin_out  <= next_bin;
         gray_out <= gray_next;
         at_max   <= (next_bin == TC);
         ovf      <= next_ovf;
      end
   end

endmodule
